// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch, redirect and delivery signals of the instruction fetch queue
//
// Ports (master = the queue, slave = IROM, branch unit and decode side):
//   inst_addr   master->slave  IROM word address
//   inst_req    master->slave  IROM read issued this cycle
//   inst        slave->master  IROM data, valid the cycle after inst_req
//   redirect    slave->master  branch/jump taken: flush and refetch
//   redirect_pc slave->master  redirect target
//   out_valid   master->slave  head entry available
//   out_ready   slave->master  consumer accepts head
//   out_inst    master->slave  head instruction
//   out_pc      master->slave  head pc
//   out_pc4     master->slave  head pc + 4
//   count       master->slave  queue occupancy
interface ifetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] inst_addr;
  logic              inst_req;
  logic [31:0]       inst;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc4;
  logic [CNT_W-1:0]  count;

  modport master (
    output inst_addr, inst_req, out_valid, out_inst, out_pc, out_pc4, count,
    input  inst, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  inst_addr, inst_req, out_valid, out_inst, out_pc, out_pc4, count,
    output inst, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue between a 1-cycle IROM and decode
//
// Ports:
//   cpu_clk  in   clock, all state updates on the rising edge
//   cpu_rst  in   asynchronous active-low reset
//   bus      master modport of ifetch_queue_if (IROM request/response,
//            redirect, head-of-queue handshake, occupancy)
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           cpu_clk,
  input  logic           cpu_rst,
  ifetch_queue_if.master bus
);
  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_inst_q [DEPTH];
  logic [31:0]      fifo_inst_d [DEPTH];
  logic [31:0]      fifo_pc_q   [DEPTH];
  logic [31:0]      fifo_pc_d   [DEPTH];

  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  logic             out_valid_w;

  // An outstanding IROM read reserves a slot, so a request is only issued
  // when the returning word is guaranteed somewhere to land.
  always_comb begin
    occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue       = cpu_rst && !bus.redirect && (occupancy < DEPTH_W);
    out_valid_w = cpu_rst && (count_q != '0) && !bus.redirect;
    pop         = out_valid_w && bus.out_ready;
    push        = inflight_q && !bus.redirect;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = inflight_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;

    if (bus.redirect) begin
      // Flush wins over everything; the word in flight is simply dropped.
      fetch_pc_d = bus.redirect_pc & ~32'd3;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
      if (push) begin
        fifo_inst_d[tail_q] = bus.inst;
        fifo_pc_d[tail_q]   = req_pc_q;
        tail_d              = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

  // Head data is gated by reset so it reads 0 immediately, before any edge.
  assign bus.inst_addr = fetch_pc_q[ADDR_W+1:2];
  assign bus.inst_req  = issue;
  assign bus.out_valid = out_valid_w;
  assign bus.out_inst  = cpu_rst ? fifo_inst_q[head_q] : 32'd0;
  assign bus.out_pc    = cpu_rst ? fifo_pc_q[head_q] : 32'd0;
  assign bus.out_pc4   = cpu_rst ? (fifo_pc_q[head_q] + 32'd4) : 32'd0;
  assign bus.count     = count_q;
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of 2, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 14: IROM word-address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 SHALL use one clock, cpu_clk; reset cpu_rst is asynchronous and active-low.
REQ-005 SHALL have port cpu_clk  input  1: clock; all state updates on its rising edge.
REQ-006 SHALL have port cpu_rst  input  1: asynchronous active-low reset.
REQ-007 SHALL have port inst_addr  output  ADDR_W: IROM word address, equal to fetch_pc[ADDR_W+1:2].
REQ-008 SHALL have port inst_req  output  1: IROM read issued this cycle.
REQ-009 SHALL have port inst  input  32: IROM data, valid the cycle after inst_req.
REQ-010 SHALL have port redirect  input  1: branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc  input  32: redirect target.
REQ-012 SHALL have port out_valid  output  1: head entry available.
REQ-013 SHALL have port out_ready  input  1: consumer accepts head.
REQ-014 SHALL have port out_inst  output  32: head instruction.
REQ-015 SHALL have port out_pc  output  32: head PC.
REQ-016 SHALL have port out_pc4  output  32: out_pc + 4, modulo 2^32.
REQ-017 SHALL have port count  output  $clog2(DEPTH+1): current queue occupancy.

Function
REQ-018 SHALL hold fetch_pc, a FIFO of DEPTH {inst, pc} entries, an inflight flag and req_pc.
REQ-019 SHALL assert inst_req when redirect=0 and count + inflight < DEPTH; fetch_pc SHALL advance by 4 (wrapping 0xFFFFFFFC->0) on each issued request.
REQ-020 SHALL, on an issued request, set inflight=1 and latch req_pc=fetch_pc; otherwise clear inflight at the edge.
REQ-021 SHALL push {inst, req_pc} at the FIFO tail at the end of a cycle where inflight=1 and redirect=0.
REQ-022 SHALL drive out_valid = (count != 0) and redirect=0; a pop occurs when out_valid and out_ready are both 1.
REQ-023 SHALL present out_inst/out_pc from the FIFO head combinationally, with no bypass from inst; fetch-to-out_valid latency is 2 cycles.
REQ-024 SHALL keep count unchanged on a simultaneous push and pop; count SHALL never exceed DEPTH and SHALL never underflow.
REQ-025 SHALL wrap head/tail pointers modulo DEPTH.
REQ-026 SHALL sustain one instruction per cycle when DEPTH>=4 and out_ready stays 1.
REQ-027 SHALL, on redirect=1, at the next edge: empty the FIFO (count=0), discard any inflight data, clear inflight, and load fetch_pc = {redirect_pc[31:2], 2'b00}; no pop and no push occur in that cycle.
REQ-028 SHALL give redirect priority over all other events in the same cycle.
REQ-029 SHALL order consecutive redirects so that the last one wins.

Reset
REQ-030 SHALL, while cpu_rst=0, force immediately: fetch_pc=RESET_PC, FIFO empty, pointers 0, inflight=0, count=0, out_valid=0, inst_req=0.
REQ-031 SHALL drive out_inst, out_pc and out_pc4 to 0 during reset.
REQ-032 SHALL issue the first request at RESET_PC in the first cycle after cpu_rst rises.
REQ-033 SHALL apply reset asserted mid-operation identically, discarding all queued and inflight entries.

Verification
REQ-034 SHALL cover start-up: ROM word i = i, out_ready=1, defaults -> out_valid first high 2 cycles after the first inst_req; out_inst 0,1,2,... with out_pc 0,4,8,..., one per cycle.
REQ-035 SHALL cover backpressure: out_ready=0 -> exactly 4 requests issue, then count=4 and inst_req=0 with inst_addr held at 4; raising out_ready drains pc 0,4,8,12 in order, then fetch resumes at 0x10.
REQ-036 SHALL cover flush: count=2, inflight=1, redirect=1 with redirect_pc=0x100 -> next cycle count=0, out_valid=0, stale data never appears; the next delivered out_pc is 0x100 and out_pc4 is 0x104.
REQ-037 SHALL cover misaligned redirect: redirect_pc=0x103 -> inst_addr=0x40 and out_pc=0x100.
REQ-038 SHALL cover async reset: cpu_rst driven low between clock edges mid-stream -> out_valid, inst_req and count drop to 0 without waiting for an edge; after release, fetch restarts at RESET_PC.
REQ-039 SHALL cover PC wrap: redirect to 0xFFFFFFF8 -> delivered out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; out_pc4 at 0xFFFFFFFC is 0.
